tx_frame_axis_packer: RTL and testbench

TX_FRAME_AXIS_PACKER -- requirements
Module: tx_frame_axis_packer

---
 rtl/tx_frame_axis_packer_pkg.sv | 23 ++
 rtl/tx_frame_axis_packer_two_fifo.sv | 51 +++++
 rtl/tx_frame_axis_packer.sv | 153 +++++++++++++++
 tb/tb_tx_frame_axis_packer.sv | 405 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_frame_axis_packer_pkg.sv
// Shared ethernet TX definitions: FSM states, external status codes, length field width.
package tx_frame_axis_packer_pkg;

  localparam int eth_len_width_lp = 16;

  typedef enum logic {
    e_idle,
    e_data
  } tx_state_e;

  typedef enum logic [1:0] {
    e_ext_idle    = 2'b00,
    e_ext_busy    = 2'b01,
    e_ext_len_err = 2'b10
  } tx_ext_state_e;

  // Byte enables for the final beat given length mod 8 (0 means a full beat).
  function automatic logic [7:0] last_keep_f(input logic [2:0] rem);
    if (rem == 3'd0) return 8'hFF;
    else return (8'h01 << rem) - 8'h01;
  endfunction

endpackage

// File: rtl/tx_frame_axis_packer_two_fifo.sv
// Two-entry valid/ready -> valid/yumi buffer; ready looks through a same-cycle dequeue.
module tx_frame_axis_packer_two_fifo #(
  parameter int width_p = 73
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic [width_p-1:0] data_i,
  input  logic               v_i,
  output logic               ready_o,
  output logic [width_p-1:0] data_o,
  output logic               v_o,
  input  logic               yumi_i
);

  logic [width_p-1:0] mem_q [2];
  logic               wr_ptr_q, wr_ptr_d;
  logic               rd_ptr_q, rd_ptr_d;
  logic [1:0]         count_q, count_d;
  logic               enq, deq;

  assign ready_o = (count_q != 2'd2) | yumi_i;
  assign v_o     = (count_q != 2'd0);
  assign data_o  = mem_q[rd_ptr_q];
  assign enq     = v_i & ready_o;
  assign deq     = yumi_i;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (enq) wr_ptr_d = ~wr_ptr_q;
    if (deq) rd_ptr_d = ~rd_ptr_q;
    count_d = count_q + {1'b0, enq} - {1'b0, deq};
  end

  // Pointer/occupancy registers; storage needs no reset.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      if (enq) mem_q[wr_ptr_q] <= data_i;
    end
  end

endmodule

// File: rtl/tx_frame_axis_packer.sv
// Packs MMIO frame words (length word, then payload words) into AXIS beats.
//
// state  | meaning
// e_idle | waiting for a length word; bad lengths set the sticky error flag
// e_data | forwarding payload words; down-counter hits 1 on the final beat
module tx_frame_axis_packer
  import tx_frame_axis_packer_pkg::*;
#(
  parameter int axis_data_width_p = 64,
  parameter int max_frame_bytes_p = 1536
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic [axis_data_width_p-1:0]   frame_data_i,
  input  logic                           frame_data_v_i,
  output logic                           frame_data_yumi_o,
  output logic [axis_data_width_p-1:0]   tx_axis_tdata_o,
  output logic [axis_data_width_p/8-1:0] tx_axis_tkeep_o,
  output logic                           tx_axis_tvalid_o,
  input  logic                           tx_axis_tready_i,
  output logic                           tx_axis_tlast_o,
  output logic                           tx_axis_tuser_o,
  output logic [1:0]                     tx_ext_state_o,
  output logic [15:0]                    frames_sent_o
);

  localparam int keep_width_lp = axis_data_width_p / 8;
  localparam int beat_width_lp = axis_data_width_p + keep_width_lp + 1;
  localparam int cnt_width_lp  = eth_len_width_lp - 2;
  localparam logic [eth_len_width_lp-1:0] max_len_lp = eth_len_width_lp'(max_frame_bytes_p);

  tx_state_e                  state_q, state_d;
  logic [cnt_width_lp-1:0]    beats_left_q, beats_left_d;
  logic [keep_width_lp-1:0]   last_keep_q, last_keep_d;
  logic                       len_err_q, len_err_d;
  logic [15:0]                frames_sent_q, frames_sent_d;

  logic [eth_len_width_lp-1:0] len_w;
  logic                        len_ok;
  logic [cnt_width_lp-1:0]     beat_count;
  logic                        final_beat;
  logic                        yumi;
  logic                        enq_v;
  logic [keep_width_lp-1:0]    enq_keep;
  logic                        enq_last;
  logic                        fifo_ready;
  logic                        fifo_v;
  logic [beat_width_lp-1:0]    fifo_data;
  logic                        beat_accept;

  assign len_w      = frame_data_i[eth_len_width_lp-1:0];
  assign len_ok     = (len_w != '0) && (len_w <= max_len_lp);
  assign beat_count = {1'b0, len_w[eth_len_width_lp-1:3]} + cnt_width_lp'(|len_w[2:0]);
  assign final_beat = (beats_left_q == cnt_width_lp'(1));

  // Next-state and word-consume logic; outputs held inactive while in reset.
  always_comb begin
    state_d      = state_q;
    beats_left_d = beats_left_q;
    last_keep_d  = last_keep_q;
    len_err_d    = len_err_q;
    yumi         = 1'b0;
    enq_v        = 1'b0;
    enq_keep     = '1;
    enq_last     = 1'b0;
    case (state_q)
      e_idle: begin
        yumi = frame_data_v_i;
        if (frame_data_v_i) begin
          if (len_ok) begin
            beats_left_d = beat_count;
            last_keep_d  = last_keep_f(len_w[2:0]);
            len_err_d    = 1'b0;
            state_d      = e_data;
          end else begin
            len_err_d = 1'b1;
          end
        end
      end
      e_data: begin
        yumi  = frame_data_v_i & fifo_ready;
        enq_v = yumi;
        if (final_beat) begin
          enq_keep = last_keep_q;
          enq_last = 1'b1;
        end
        if (yumi) begin
          beats_left_d = beats_left_q - cnt_width_lp'(1);
          if (final_beat) state_d = e_idle;
        end
      end
      default: state_d = e_idle;
    endcase
    if (reset_i) begin
      yumi  = 1'b0;
      enq_v = 1'b0;
    end
  end

  tx_frame_axis_packer_two_fifo #(
    .width_p(beat_width_lp)
  ) two_fifo (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .data_i ({frame_data_i, enq_keep, enq_last}),
    .v_i    (enq_v),
    .ready_o(fifo_ready),
    .data_o (fifo_data),
    .v_o    (fifo_v),
    .yumi_i (beat_accept)
  );

  assign tx_axis_tvalid_o = fifo_v & ~reset_i;
  assign beat_accept      = tx_axis_tvalid_o & tx_axis_tready_i;

  // Completed-frame counter, wraps naturally at 16 bits.
  always_comb begin
    frames_sent_d = frames_sent_q + 16'(beat_accept & fifo_data[0]);
  end

  // State, counter and flag registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q       <= e_idle;
      beats_left_q  <= '0;
      last_keep_q   <= '0;
      len_err_q     <= 1'b0;
      frames_sent_q <= 16'd0;
    end else begin
      state_q       <= state_d;
      beats_left_q  <= beats_left_d;
      last_keep_q   <= last_keep_d;
      len_err_q     <= len_err_d;
      frames_sent_q <= frames_sent_d;
    end
  end

  // External status, error taking priority over busy.
  always_comb begin
    tx_ext_state_o = e_ext_idle;
    if (reset_i)                            tx_ext_state_o = e_ext_idle;
    else if (len_err_q)                     tx_ext_state_o = e_ext_len_err;
    else if ((state_q == e_data) || fifo_v) tx_ext_state_o = e_ext_busy;
  end

  assign frame_data_yumi_o = yumi;
  assign tx_axis_tdata_o   = fifo_data[beat_width_lp-1:keep_width_lp+1];
  assign tx_axis_tkeep_o   = fifo_data[keep_width_lp:1];
  assign tx_axis_tlast_o   = fifo_data[0];
  assign tx_axis_tuser_o   = 1'b0;
  assign frames_sent_o     = frames_sent_q;

endmodule

// File: tb/tb_tx_frame_axis_packer.sv
// Testbench for tx_frame_axis_packer: frame table, corner sequences, random frames vs. model.
module tb_tx_frame_axis_packer;

  logic        clk = 1'b0;
  logic        reset_i;
  logic [63:0] frame_data_i;
  logic        frame_data_v_i;
  logic        frame_data_yumi_o;
  logic [63:0] tx_axis_tdata_o;
  logic [7:0]  tx_axis_tkeep_o;
  logic        tx_axis_tvalid_o;
  logic        tx_axis_tready_i;
  logic        tx_axis_tlast_o;
  logic        tx_axis_tuser_o;
  logic [1:0]  tx_ext_state_o;
  logic [15:0] frames_sent_o;

  always #5 clk = ~clk;

  tx_frame_axis_packer dut (
    .clk_i            (clk),
    .reset_i          (reset_i),
    .frame_data_i     (frame_data_i),
    .frame_data_v_i   (frame_data_v_i),
    .frame_data_yumi_o(frame_data_yumi_o),
    .tx_axis_tdata_o  (tx_axis_tdata_o),
    .tx_axis_tkeep_o  (tx_axis_tkeep_o),
    .tx_axis_tvalid_o (tx_axis_tvalid_o),
    .tx_axis_tready_i (tx_axis_tready_i),
    .tx_axis_tlast_o  (tx_axis_tlast_o),
    .tx_axis_tuser_o  (tx_axis_tuser_o),
    .tx_ext_state_o   (tx_ext_state_o),
    .frames_sent_o    (frames_sent_o)
  );

  typedef struct {
    logic [63:0] data;
    logic [7:0]  keep;
    logic        last;
  } beat_t;

  typedef struct {
    logic [63:0] len_word;
    int          n_beats;
    logic [7:0]  last_keep;
    logic [1:0]  state;
  } vec_t;

  beat_t       exp_q[$];
  int          acc_cyc_q[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          acc_cnt = 0;
  int          last_yumi_cyc = 0;
  int          first_pay_cyc = 0;
  logic [7:0]  last_keep_seen = 8'h00;
  logic [15:0] exp_frames = 16'd0;
  int          rdy_mode = 1;
  bit          gap_en = 1'b0;

  bit          stall_prev = 1'b0;
  logic [63:0] prev_data;
  logic [7:0]  prev_keep;
  logic        prev_last;
  beat_t       mon_e;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  initial begin
    tx_axis_tready_i = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 2) tx_axis_tready_i = 1'($urandom_range(0, 1));
      else               tx_axis_tready_i = (rdy_mode == 1);
    end
  end

  // Output monitor: AXIS hold rule and in-order scoreboard against the model queue.
  initial forever begin
    @(negedge clk);
    if (reset_i) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (!(tx_axis_tvalid_o && tx_axis_tdata_o == prev_data &&
              tx_axis_tkeep_o == prev_keep && tx_axis_tlast_o == prev_last)) begin
          errors++;
          $display("FAIL axis_hold: got v=%b d=%h k=%h l=%b expected v=1 d=%h k=%h l=%b",
                   tx_axis_tvalid_o, tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tlast_o,
                   prev_data, prev_keep, prev_last);
        end
      end
      if (tx_axis_tvalid_o && tx_axis_tready_i) begin
        acc_cnt++;
        acc_cyc_q.push_back(cyc);
        last_keep_seen = tx_axis_tkeep_o;
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_beat: got d=%h k=%h l=%b expected no beat",
                   tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tlast_o);
        end else begin
          mon_e = exp_q.pop_front();
          if ({tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tlast_o, tx_axis_tuser_o} !==
              {mon_e.data, mon_e.keep, mon_e.last, 1'b0}) begin
            errors++;
            $display("FAIL beat: got d=%h k=%h l=%b u=%b expected d=%h k=%h l=%b u=0",
                     tx_axis_tdata_o, tx_axis_tkeep_o, tx_axis_tlast_o, tx_axis_tuser_o,
                     mon_e.data, mon_e.keep, mon_e.last);
          end
        end
      end
      stall_prev = tx_axis_tvalid_o && !tx_axis_tready_i;
      prev_data  = tx_axis_tdata_o;
      prev_keep  = tx_axis_tkeep_o;
      prev_last  = tx_axis_tlast_o;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] keep_for(input int bytes);
    logic [7:0] k = 8'h00;
    for (int b = 0; b < 8; b++) if (b < bytes) k[b] = 1'b1;
    return k;
  endfunction

  task automatic resync();
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [63:0] w);
    int n = 0;
    if (gap_en) repeat ($urandom_range(0, 2)) resync();
    frame_data_i   = w;
    frame_data_v_i = 1'b1;
    @(negedge clk);
    while (!frame_data_yumi_o && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (!frame_data_yumi_o) begin
      checks++;
      errors++;
      $display("FAIL push_timeout: got no yumi expected yumi for word %h", w);
    end
    last_yumi_cyc = cyc;
    resync();
    frame_data_v_i = 1'b0;
  endtask

  // Model: a legal length yields ceil(L/8) beats, each carrying min(8, bytes left) enabled bytes.
  task automatic send_frame(input logic [63:0] len_word, input int n_send);
    int    len;
    int    nb;
    int    bytes;
    beat_t b;
    len = int'(len_word[15:0]);
    push_word(len_word);
    if (len >= 1 && len <= 1536) begin
      nb = (len + 7) / 8;
      for (int i = 0; i < nb; i++) begin
        bytes = len - 8 * i;
        if (bytes > 8) bytes = 8;
        b.data = {$urandom(), $urandom()};
        b.keep = keep_for(bytes);
        b.last = (i == nb - 1);
        exp_q.push_back(b);
        if (n_send < 0 || i < n_send) begin
          push_word(b.data);
          if (i == 0) first_pay_cyc = last_yumi_cyc;
        end
      end
      if (n_send < 0) exp_frames++;
    end
  endtask

  task automatic drain();
    int n = 0;
    @(negedge clk);
    while ((exp_q.size() != 0 || tx_axis_tvalid_o) && n < 4000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 4000) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout: got %0d beats pending expected 0", exp_q.size());
    end
    resync();
  endtask

  vec_t        vecs[$];
  vec_t        v;
  int          base;
  int          n;
  int          len;
  logic [63:0] w[8];
  beat_t       b;

  initial begin
    vecs.push_back('{64'h0000_0000_0000_0014,   3, 8'h0F, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0000,   0, 8'h00, 2'b10});
    vecs.push_back('{64'h0000_0000_0000_07D0,   0, 8'h00, 2'b10});
    vecs.push_back('{64'h0000_0000_0000_0008,   1, 8'hFF, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0001,   1, 8'h01, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0007,   1, 8'h7F, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0009,   2, 8'h01, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0010,   2, 8'hFF, 2'b00});
    vecs.push_back('{64'h0000_0000_0000_0601,   0, 8'h00, 2'b10});
    vecs.push_back('{64'h0000_0000_0000_0600, 192, 8'hFF, 2'b00});
    vecs.push_back('{64'hDEAD_BEEF_0001_000B,   2, 8'h07, 2'b00});
    vecs.push_back('{64'hFFFF_FFFF_FFFF_0000,   0, 8'h00, 2'b10});
    vecs.push_back('{64'h0000_0000_0000_0003,   1, 8'h07, 2'b00});

    // Reset behaviour with a valid word presented.
    reset_i        = 1'b1;
    frame_data_v_i = 1'b1;
    frame_data_i   = 64'd20;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
    chk("rst_yumi",   64'(frame_data_yumi_o), 64'd0);
    chk("rst_state",  64'(tx_ext_state_o), 64'd0);
    resync();
    reset_i        = 1'b0;
    frame_data_v_i = 1'b0;
    @(negedge clk);
    chk("post_rst_frames", 64'(frames_sent_o), 64'd0);
    chk("post_rst_state",  64'(tx_ext_state_o), 64'd0);
    chk("post_rst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
    resync();

    // Table of length words with hand-derived beat counts, final keep and end state.
    foreach (vecs[k]) begin
      v    = vecs[k];
      base = acc_cnt;
      send_frame(v.len_word, -1);
      drain();
      chk($sformatf("tbl%0d_beats", k), 64'(acc_cnt - base), 64'(v.n_beats));
      if (v.n_beats > 0) chk($sformatf("tbl%0d_keep", k), 64'(last_keep_seen), 64'(v.last_keep));
      @(negedge clk);
      chk($sformatf("tbl%0d_state", k), 64'(tx_ext_state_o), 64'(v.state));
      chk($sformatf("tbl%0d_frames", k), 64'(frames_sent_o), 64'(exp_frames));
      resync();
    end

    // Error flag is sticky across bad lengths and clears to busy on the next good one.
    send_frame(64'd0, -1);
    @(negedge clk);
    chk("err0_state", 64'(tx_ext_state_o), 64'd2);
    resync();
    send_frame(64'd2000, -1);
    @(negedge clk);
    chk("err2000_state", 64'(tx_ext_state_o), 64'd2);
    resync();
    push_word(64'd8);
    @(negedge clk);
    chk("err_clear_busy", 64'(tx_ext_state_o), 64'd1);
    resync();
    b.data = 64'h0123_4567_89AB_CDEF;
    b.keep = 8'hFF;
    b.last = 1'b1;
    exp_q.push_back(b);
    push_word(b.data);
    exp_frames++;
    drain();
    @(negedge clk);
    chk("err_then_idle", 64'(tx_ext_state_o), 64'd0);
    resync();

    // Backpressure: two beats buffered, further words refused, head beat held.
    rdy_mode = 0;
    resync();
    resync();
    base = acc_cnt;
    push_word(64'd64);
    for (int i = 0; i < 8; i++) begin
      w[i]   = {$urandom(), $urandom()};
      b.data = w[i];
      b.keep = 8'hFF;
      b.last = (i == 7);
      exp_q.push_back(b);
    end
    push_word(w[0]);
    push_word(w[1]);
    frame_data_i   = w[2];
    frame_data_v_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      chk("stall_yumi",   64'(frame_data_yumi_o), 64'd0);
      chk("stall_tvalid", 64'(tx_axis_tvalid_o), 64'd1);
      chk("stall_tdata",  tx_axis_tdata_o, w[0]);
    end
    resync();
    rdy_mode = 1;
    for (int i = 2; i < 8; i++) push_word(w[i]);
    exp_frames++;
    drain();
    chk("stall_beats", 64'(acc_cnt - base), 64'd8);

    // Max-length frame streamed at full rate.
    acc_cyc_q.delete();
    send_frame(64'd1536, -1);
    drain();
    chk("max_beats", 64'(acc_cyc_q.size()), 64'd192);
    if (acc_cyc_q.size() > 0) begin
      chk("max_latency", 64'(acc_cyc_q[0]), 64'(first_pay_cyc + 1));
      chk("max_span", 64'(acc_cyc_q[acc_cyc_q.size()-1] - acc_cyc_q[0]), 64'd191);
    end

    // Reset mid-frame with beats buffered.
    base = acc_cnt;
    send_frame(64'd40, 2);
    n = 0;
    while (acc_cnt < base + 2 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("midrst_two_out", 64'(acc_cnt - base), 64'd2);
    resync();
    rdy_mode = 0;
    resync();
    resync();
    push_word(exp_q[0].data);
    push_word(exp_q[1].data);
    @(negedge clk);
    chk("midrst_buffered", 64'(tx_axis_tvalid_o), 64'd1);
    resync();
    reset_i        = 1'b1;
    frame_data_v_i = 1'b1;
    frame_data_i   = exp_q[2].data;
    rdy_mode       = 1;
    #1;
    chk("midrst_tvalid", 64'(tx_axis_tvalid_o), 64'd0);
    chk("midrst_yumi",   64'(frame_data_yumi_o), 64'd0);
    chk("midrst_state",  64'(tx_ext_state_o), 64'd0);
    resync();
    resync();
    exp_q.delete();
    exp_frames     = 16'd0;
    reset_i        = 1'b0;
    frame_data_v_i = 1'b0;
    @(negedge clk);
    chk("midrst_frames", 64'(frames_sent_o), 64'd0);
    resync();
    base = acc_cnt;
    send_frame(64'd3, -1);
    drain();
    chk("midrst_next_beats", 64'(acc_cnt - base), 64'd1);
    chk("midrst_next_keep",  64'(last_keep_seen), 64'h07);
    chk("midrst_next_frames", 64'(frames_sent_o), 64'd1);

    // Frame counter wrap from all-ones.
    @(negedge clk);
    force dut.frames_sent_q = 16'hFFFF;
    @(negedge clk);
    release dut.frames_sent_q;
    exp_frames = 16'hFFFF;
    resync();
    send_frame(64'd8, -1);
    drain();
    chk("frames_wrap", 64'(frames_sent_o), 64'(exp_frames));

    // Random frames with random gaps and backpressure.
    gap_en   = 1'b1;
    rdy_mode = 2;
    for (int f = 0; f < 25; f++) begin
      n = $urandom_range(0, 9);
      if (n == 0)      len = 0;
      else if (n == 1) len = $urandom_range(1537, 4000);
      else if (n == 2) len = 1536;
      else             len = $urandom_range(1, 100);
      send_frame({$urandom(), 16'($urandom()), 16'(len)}, -1);
      drain();
      @(negedge clk);
      chk("rnd_state",  64'(tx_ext_state_o), (len >= 1 && len <= 1536) ? 64'd0 : 64'd2);
      chk("rnd_frames", 64'(frames_sent_o), 64'(exp_frames));
      resync();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
